fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised instruction-fetch engine that assembles a `BEATS*DATA_W`-bit instruction register from consecutive `DATA_W`-bit memory words addressed by an internal program counter. It sits between the address register file / memory pair and the instruction decoder. It replaces the manual two-step low-half/high-half IR load with a self-sequenced, latency-tolerant fetch that has a start/done handshake, flush and atomic IR commit.

## Interface
- `DATA_W`, 8: memory word width.
- `ADDR_W`, 8: memory address and PC width.
- `BEATS`, 2: words per instruction, range 1..8. Word k fills `IR_Out[k*DATA_W +: DATA_W]`, low word first.
- `MEM_LAT`, 1: memory read latency in cycles, range 0..7.
- `PC_RESET`, 0: PC value after reset.
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request one instruction fetch.
- `Flush`  in  1  abort an in-progress fetch.
- `PC_Load`  in  1  load PC from `PC_In`.
- `PC_In`  in  ADDR_W  PC load value.
- `Mem_Data`  in  DATA_W  memory read data.
- `Mem_Addr`  out  ADDR_W  memory address; always equals PC.
- `Mem_CS`  out  1  read strobe, active-high, one cycle per beat.
- `Mem_WR`  out  1  tied 0 (read only).
- `IR_Out`  out  BEATS*DATA_W  last completed instruction.
- `PC_Out`  out  ADDR_W  current PC.
- `Busy`  out  1  fetch in progress.
- `Done`  out  1  one-cycle pulse; `IR_Out` updated this cycle.

## Operation
- Reset values: PC=`PC_RESET`, `IR_Out`=0, `Busy`=0, `Done`=0, `Mem_CS`=0, `Mem_Addr`=`PC_RESET`. Staging buffer, beat counter and latency counter are 0. State is IDLE.
- States: IDLE, REQ, WAIT, DONE.
  - IDLE/DONE with `Start`=1 -> REQ. Beat counter=0. PC is saved as the fetch start address.
  - REQ: `Mem_CS`=1 for exactly this cycle. With `MEM_LAT`=0, capture `Mem_Data` into staging word[beat] at the end of this cycle. Otherwise -> WAIT, latency counter=1.
  - WAIT: when the counter reaches `MEM_LAT`, capture at the end of that cycle. Otherwise increment the counter.
  - On each capture: PC increments by 1, wrapping modulo 2^ADDR_W. If beat=BEATS-1 -> DONE; otherwise beat++ and -> REQ.
  - DONE: `Done`=1 for this cycle. The full staging buffer was copied into `IR_Out` on the entering edge. -> IDLE, or -> REQ if `Start`=1 (back-to-back fetch).
- `IR_Out` never shows a partial instruction. It changes only on entry to DONE.
- `Busy`=1 in REQ and WAIT only.
- `Start` in REQ/WAIT is ignored and not queued.
- `Flush` in REQ/WAIT: -> IDLE next edge. PC is restored to the saved start address, staging is discarded, `IR_Out` is unchanged and no `Done` is issued. `Flush` in IDLE/DONE has no effect.
- `PC_Load` is honoured in IDLE/DONE only and is ignored while `Busy`. With `PC_Load`, `Flush` and `Busy` in the same cycle, the flush restore applies and then the load overrides it: PC=`PC_In`.
- With `Start` and `PC_Load` in the same IDLE cycle, the fetch begins at `PC_In`. The saved start address is `PC_In`.
- An asynchronous `Reset` mid-fetch returns to all reset values immediately. No `Done` is issued.

## Timing
- Each beat takes 1+`MEM_LAT` cycles. Start-to-`Done` latency is `BEATS*(1+MEM_LAT)+1` cycles: `Start` sampled at edge 0 gives `Done` high in cycle `BEATS*(1+MEM_LAT)+1`.
- Back-to-back issue: a `Start` sampled during `Done` puts REQ in the next cycle, so throughput is one instruction per `BEATS*(1+MEM_LAT)+1` cycles.
- `Mem_Data` must be stable in the capture cycle, which is cycle REQ+`MEM_LAT`.
- `PC_Out` and `Mem_Addr` change only on capture edges, load edges, flush edges and reset.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum {IDLE, REQ, WAIT, DONE};
  - parameter range-check constants (`BEATS_MAX`=8, `MEM_LAT_MAX`=7).
- One sub-module, `pc_register`: `ADDR_W` loadable incrementer with a save/restore slot. Priority is load > restore > increment.
- Elaboration-time check rejects `BEATS` or `MEM_LAT` outside their ranges.

## Test plan
- Defaults, memory[0]=0x34, memory[1]=0x12, `Start` at cycle 0 -> `Done` in cycle 5, `IR_Out`=0x1234, `PC_Out`=2, `Mem_CS` high in cycles 1 and 3 only.
- `MEM_LAT`=0, `BEATS`=4, PC loaded 0xFE, memory 0xFE..0x01 = 0xAA, 0xBB, 0xCC, 0xDD -> `Done` in cycle 5, `IR_Out`=0xDDCCBBAA, PC wraps to 0x02.
- `Flush` in cycle 3 of a default fetch from PC=0x10 -> IDLE at cycle 4, PC=0x10, `IR_Out` unchanged, no `Done`. A second `Start` fetching 0x10/0x11 completes normally.
- `Start` held high continuously -> `Done` pulses every 5 cycles (defaults). Each `IR_Out` uses consecutive address pairs.
- `PC_Load`=1 with `PC_In`=0x40 while `Busy` -> ignored, fetch completes from the original PC. `PC_Load` with `Flush` -> PC=0x40.
- `Reset` asserted mid-WAIT -> all outputs at reset values asynchronously, before the next edge. No `Done` after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetchState_t : sequencer states
//   BEATS_MAX    : largest supported words-per-instruction
//   MEM_LAT_MAX  : largest supported memory read latency
//   CNT_W        : width of the beat and latency counters
package fetch_pkg;

    localparam int unsigned BEATS_MAX   = 8;
    localparam int unsigned MEM_LAT_MAX = 7;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } fetchState_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with a save/restore slot.
// Priority: load > restore > increment. The save slot records the value
// the PC holds after this edge's load (if any), so a fetch started with a
// simultaneous load remembers the loaded address.
//   Clock, Reset : clock, async active-high reset
//   load/loadValue : overwrite PC
//   restore        : PC <= saved slot
//   increment      : PC <= PC + 1 (wraps)
//   save           : slot <= post-load PC
//   pc             : current PC
module pc_register #(
    parameter int unsigned        ADDR_W      = 8,
    parameter logic [ADDR_W-1:0]  RESET_VALUE = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadValue,
    input  logic              restore,
    input  logic              increment,
    input  logic              save,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] savedPc;

    // PC update
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= loadValue;
        end else if (restore) begin
            pc <= savedPc;
        end else if (increment) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Fetch start address slot
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            savedPc <= RESET_VALUE;
        end else if (save) begin
            savedPc <= load ? loadValue : pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Self-sequenced instruction fetch: reads BEATS consecutive DATA_W words
// starting at the PC and commits them atomically into IR_Out.
//   Clock, Reset        : clock, async active-high reset
//   Start, Flush        : fetch request / abort in-progress fetch
//   PC_Load, PC_In      : PC load (idle/done, or together with Flush)
//   Mem_Data            : memory read data
//   Mem_Addr, Mem_CS    : memory address (= PC) and one-cycle read strobe
//   Mem_WR              : always 0
//   IR_Out, PC_Out      : last complete instruction, current PC
//   Busy, Done          : fetch in progress / IR_Out updated this cycle
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        BEATS    = 2,
    parameter int unsigned        MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Flush,
    input  logic                    PC_Load,
    input  logic [ADDR_W-1:0]       PC_In,
    input  logic [DATA_W-1:0]       Mem_Data,
    output logic [ADDR_W-1:0]       Mem_Addr,
    output logic                    Mem_CS,
    output logic                    Mem_WR,
    output logic [BEATS*DATA_W-1:0] IR_Out,
    output logic [ADDR_W-1:0]       PC_Out,
    output logic                    Busy,
    output logic                    Done
);

    localparam int unsigned       IR_W       = BEATS * DATA_W;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  LAT_TARGET = CNT_W'(MEM_LAT);

    if (BEATS < 1 || BEATS > BEATS_MAX) begin : gBeatsRange
        $error("fetch_sequencer: BEATS out of range");
    end
    if (MEM_LAT > MEM_LAT_MAX) begin : gLatRange
        $error("fetch_sequencer: MEM_LAT out of range");
    end

    fetchState_t       state, nextState;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  latCnt;
    logic [IR_W-1:0]   staging, stagingNext;
    logic [IR_W-1:0]   irReg;
    logic              busyReg, doneReg, memCsReg;
    logic              beatReady;
    logic              pcLoad, pcRestore, pcIncrement, pcSave;
    logic [ADDR_W-1:0] pc;

    pc_register #(
        .ADDR_W      (ADDR_W),
        .RESET_VALUE (PC_RESET)
    ) uPc (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (pcLoad),
        .loadValue (PC_In),
        .restore   (pcRestore),
        .increment (pcIncrement),
        .save      (pcSave),
        .pc        (pc)
    );

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and PC control
    always_comb begin
        nextState   = state;
        beatReady   = 1'b0;
        pcSave      = 1'b0;
        pcRestore   = 1'b0;
        pcIncrement = 1'b0;
        stagingNext = staging;
        stagingNext[beat*DATA_W +: DATA_W] = Mem_Data;

        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    nextState = REQ;
                    pcSave    = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            REQ, WAIT: begin
                // Zero latency captures in REQ; otherwise the last WAIT cycle
                beatReady = (state == REQ) ? (MEM_LAT == 0) : (latCnt == LAT_TARGET);
                if (Flush) begin
                    nextState = IDLE;
                    pcRestore = 1'b1;
                end else if (beatReady) begin
                    pcIncrement = 1'b1;
                    nextState   = (beat == LAST_BEAT) ? DONE : REQ;
                end else begin
                    nextState = WAIT;
                end
            end
            default: nextState = IDLE;
        endcase

        // Loads are ignored mid-fetch unless they accompany a flush
        pcLoad = PC_Load && (!(state == REQ || state == WAIT) || Flush);
    end

    // Datapath and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            beat     <= '0;
            latCnt   <= '0;
            staging  <= '0;
            irReg    <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            memCsReg <= 1'b0;
        end else begin
            busyReg  <= (nextState == REQ) || (nextState == WAIT);
            doneReg  <= (nextState == DONE);
            memCsReg <= (nextState == REQ);
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        beat   <= '0;
                        latCnt <= '0;
                    end
                end
                REQ, WAIT: begin
                    if (Flush) begin
                        beat    <= '0;
                        latCnt  <= '0;
                        staging <= '0;
                    end else if (pcIncrement) begin
                        staging <= stagingNext;
                        latCnt  <= '0;
                        if (beat == LAST_BEAT) begin
                            irReg <= stagingNext;
                            beat  <= '0;
                        end else begin
                            beat <= beat + CNT_W'(1);
                        end
                    end else begin
                        latCnt <= latCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Mem_Addr = pc;
    assign PC_Out   = pc;
    assign Mem_CS   = memCsReg;
    assign Mem_WR   = 1'b0;
    assign IR_Out   = irReg;
    assign Busy     = busyReg;
    assign Done     = doneReg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer: a default instance
// (BEATS=2, MEM_LAT=1) and a wide zero-latency instance (BEATS=4, MEM_LAT=0)
// share one memory array; expectations come from address arithmetic over it.
module tb_fetch_sequencer;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    logic [7:0] mem [256];

    // Default instance
    logic        start0, flush0, load0;
    logic [7:0]  pcIn0, memData0, memAddr0, pcOut0;
    logic        memCs0, memWr0, busy0, done0;
    logic [15:0] ir0;
    assign memData0 = mem[memAddr0];

    // Four-beat zero-latency instance
    logic        start1, flush1, load1;
    logic [7:0]  pcIn1, memData1, memAddr1, pcOut1;
    logic        memCs1, memWr1, busy1, done1;
    logic [31:0] ir1;
    assign memData1 = mem[memAddr1];

    fetch_sequencer dut0 (
        .Clock(Clock), .Reset(Reset), .Start(start0), .Flush(flush0),
        .PC_Load(load0), .PC_In(pcIn0), .Mem_Data(memData0),
        .Mem_Addr(memAddr0), .Mem_CS(memCs0), .Mem_WR(memWr0),
        .IR_Out(ir0), .PC_Out(pcOut0), .Busy(busy0), .Done(done0)
    );

    fetch_sequencer #(.BEATS(4), .MEM_LAT(0)) dut1 (
        .Clock(Clock), .Reset(Reset), .Start(start1), .Flush(flush1),
        .PC_Load(load1), .PC_In(pcIn1), .Mem_Data(memData1),
        .Mem_Addr(memAddr1), .Mem_CS(memCs1), .Mem_WR(memWr1),
        .IR_Out(ir1), .PC_Out(pcOut1), .Busy(busy1), .Done(done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Instruction formed from `beats` consecutive bytes, low address in low bits
    function automatic logic [63:0] modelIr(input logic [7:0] pc, input int beats);
        logic [63:0] r = '0;
        for (int k = 0; k < beats; k++) begin
            r = r | (64'(mem[8'(pc + 8'(k))]) << (8 * k));
        end
        return r;
    endfunction

    // Issue Start (with any preset load), count cycles to Done; returns with
    // the bench sitting in the Done cycle (lat=0 if Done never came)
    task automatic runFetch0(input bit holdStart, output int lat, output logic [15:0] csBits);
        start0 = 1'b1;
        tick();
        start0 = holdStart;
        load0  = 1'b0;
        lat    = 0;
        csBits = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c < 16 && memCs0) csBits[c] = 1'b1;
            if (done0) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic runFetch1(output int lat);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        load1  = 1'b0;
        lat    = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done1) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int          lat;
        int          doneSeen;
        logic [15:0] cs;
        logic [15:0] irBefore;
        logic [7:0]  p;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        start0 = 0; flush0 = 0; load0 = 0; pcIn0 = 0;
        start1 = 0; flush1 = 0; load1 = 0; pcIn1 = 0;

        // Reset values
        Reset = 1'b1;
        #1;
        check("rst_ir", 64'(ir0), 64'h0);
        check("rst_pc", 64'(pcOut0), 64'h0);
        check("rst_addr", 64'(memAddr0), 64'h0);
        check("rst_busy", 64'(busy0), 64'h0);
        check("rst_done", 64'(done0), 64'h0);
        check("rst_cs", 64'(memCs0), 64'h0);
        check("rst_wr", 64'(memWr0), 64'h0);
        tick();
        Reset = 1'b0;
        tick();

        // Basic two-beat fetch from address 0
        mem[0] = 8'h34;
        mem[1] = 8'h12;
        runFetch0(1'b0, lat, cs);
        check("basic_lat", 64'(lat), 64'd5);
        check("basic_ir", 64'(ir0), 64'h1234);
        check("basic_pc", 64'(pcOut0), 64'd2);
        check("basic_cs_cycles", 64'(cs), 64'b1010);
        tick();
        check("basic_done_pulse", 64'(done0), 64'h0);

        // Flush mid-fetch from 0x10
        load0 = 1'b1; pcIn0 = 8'h10;
        tick();
        load0 = 1'b0;
        check("load_pc", 64'(pcOut0), 64'h10);
        irBefore = ir0;
        start0 = 1'b1;
        tick();                      // cycle 1
        start0 = 1'b0;
        check("busy_req", 64'(busy0), 64'h1);
        tick();                      // cycle 2
        tick();                      // cycle 3
        check("pc_mid_fetch", 64'(pcOut0), 64'h11);
        flush0 = 1'b1;
        tick();                      // cycle 4
        flush0 = 1'b0;
        check("flush_busy", 64'(busy0), 64'h0);
        check("flush_pc", 64'(pcOut0), 64'h10);
        check("flush_ir", 64'(ir0), 64'(irBefore));
        doneSeen = 0;
        for (int c = 0; c < 6; c++) begin
            if (done0) doneSeen++;
            tick();
        end
        check("flush_no_done", 64'(doneSeen), 64'h0);
        runFetch0(1'b0, lat, cs);
        check("post_flush_lat", 64'(lat), 64'd5);
        check("post_flush_ir", 64'(ir0), modelIr(8'h10, 2));
        check("post_flush_pc", 64'(pcOut0), 64'h12);
        tick();

        // Start held high: back-to-back fetches on consecutive pairs
        p = pcOut0;
        for (int n = 0; n < 3; n++) begin
            runFetch0(1'b1, lat, cs);
            check("b2b_lat", 64'(lat), 64'd5);
            check("b2b_ir", 64'(ir0), modelIr(8'(p + 8'(2 * n)), 2));
        end
        start0 = 1'b0;
        tick();
        check("b2b_idle", 64'(busy0), 64'h0);
        check("b2b_pc", 64'(pcOut0), 64'(8'(p + 8'd6)));

        // PC_Load while busy is ignored
        p = pcOut0;
        start0 = 1'b1;
        tick();                      // cycle 1
        start0 = 1'b0;
        load0 = 1'b1; pcIn0 = 8'h40;
        tick();                      // cycle 2
        tick();                      // cycle 3
        load0 = 1'b0;
        lat = 0;
        for (int c = 3; c <= 40; c++) begin
            if (done0) begin
                lat = c;
                break;
            end
            tick();
        end
        check("busy_load_lat", 64'(lat), 64'd5);
        check("busy_load_ir", 64'(ir0), modelIr(p, 2));
        check("busy_load_pc", 64'(pcOut0), 64'(8'(p + 8'd2)));
        tick();

        // PC_Load together with Flush overrides the restore
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        flush0 = 1'b1; load0 = 1'b1; pcIn0 = 8'h40;
        tick();
        flush0 = 1'b0; load0 = 1'b0;
        check("flush_load_pc", 64'(pcOut0), 64'h40);
        check("flush_load_busy", 64'(busy0), 64'h0);

        // Start with simultaneous load begins at the loaded address
        load0 = 1'b1; pcIn0 = 8'h80;
        runFetch0(1'b0, lat, cs);
        check("start_load_ir", 64'(ir0), modelIr(8'h80, 2));
        check("start_load_pc", 64'(pcOut0), 64'h82);
        tick();

        // Asynchronous reset mid-WAIT
        start0 = 1'b1;
        tick();                      // REQ
        start0 = 1'b0;
        tick();                      // WAIT
        Reset = 1'b1;
        #1;
        check("async_rst_pc", 64'(pcOut0), 64'h0);
        check("async_rst_ir", 64'(ir0), 64'h0);
        check("async_rst_busy", 64'(busy0), 64'h0);
        check("async_rst_cs", 64'(memCs0), 64'h0);
        tick();
        Reset = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 8; c++) begin
            if (done0) doneSeen++;
            tick();
        end
        check("async_rst_no_done", 64'(doneSeen), 64'h0);

        // Randomized fetches from random addresses
        for (int n = 0; n < 20; n++) begin
            p = 8'($urandom);
            mem[p] = 8'($urandom);
            mem[8'(p + 8'd1)] = 8'($urandom);
            load0 = 1'b1; pcIn0 = p;
            runFetch0(1'b0, lat, cs);
            check("rand_lat", 64'(lat), 64'd5);
            check("rand_ir", 64'(ir0), modelIr(p, 2));
            check("rand_pc", 64'(pcOut0), 64'(8'(p + 8'd2)));
            for (int w = 0; w < int'($urandom_range(0, 3)) + 1; w++) tick();
        end

        // Four-beat, zero-latency instance with PC wrap
        mem[8'hFE] = 8'hAA;
        mem[8'hFF] = 8'hBB;
        mem[8'h00] = 8'hCC;
        mem[8'h01] = 8'hDD;
        load1 = 1'b1; pcIn1 = 8'hFE;
        tick();
        load1 = 1'b0;
        runFetch1(lat);
        check("wide_lat", 64'(lat), 64'd5);
        check("wide_ir", 64'(ir1), 64'hDDCCBBAA);
        check("wide_pc", 64'(pcOut1), 64'h02);
        tick();
        for (int n = 0; n < 8; n++) begin
            p = 8'($urandom);
            load1 = 1'b1; pcIn1 = p;
            runFetch1(lat);
            check("wide_rand_lat", 64'(lat), 64'd5);
            check("wide_rand_ir", 64'(ir1), modelIr(p, 4));
            check("wide_rand_pc", 64'(pcOut1), 64'(8'(p + 8'd4)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
